// File: rtl/nand2_pkg.sv
// Shared constants and the reference NAND function for the nand2_gate block.
// Default widths are used by both RTL and bench unless overridden.
package nand2_pkg;

    localparam int unsigned NAND2_WIDTH_DEF = 1;
    localparam int unsigned NAND2_CNT_W_DEF = 16;
    localparam int unsigned NAND2_MAX_W     = 64;

    // Lane-wise NAND over the widest supported operand; callers cast down to their width.
    function automatic logic [NAND2_MAX_W-1:0] nand2_f(input logic [NAND2_MAX_W-1:0] a,
                                                       input logic [NAND2_MAX_W-1:0] b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/nand2_if.sv
// Operand/result bundle for nand2_gate; zero_cnt exists only when NAND2_STATS_EN is defined.
interface nand2_if
    import nand2_pkg::*;
#(
    parameter int unsigned WIDTH = NAND2_WIDTH_DEF,
    parameter int unsigned CNT_W = NAND2_CNT_W_DEF
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] F;
    logic             in_valid;
    logic [WIDTH-1:0] F_r;
    logic             out_valid;
`ifdef NAND2_STATS_EN
    logic [CNT_W-1:0] zero_cnt;

    modport master (output A, B, in_valid, input F, F_r, out_valid, zero_cnt);
    modport slave  (input A, B, in_valid, output F, F_r, out_valid, zero_cnt);
`else
    modport master (output A, B, in_valid, input F, F_r, out_valid);
    modport slave  (input A, B, in_valid, output F, F_r, out_valid);
`endif
endinterface

// File: rtl/nand2_cell.sv
// Single-bit combinational NAND cell.
module nand2_cell (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = ~(a_i & b_i);
endmodule

// File: rtl/nand2_gate.sv
// Lane-wise NAND with a zero-latency output F and a registered copy F_r/out_valid.
// Optional capture statistics counter enabled by NAND2_STATS_EN.
module nand2_gate
    import nand2_pkg::*;
#(
    parameter int unsigned WIDTH = NAND2_WIDTH_DEF,
    parameter int unsigned CNT_W = NAND2_CNT_W_DEF
) (
    input  logic    clk,
    input  logic    rst,
    nand2_if.slave  bus
);

    logic [WIDTH-1:0] f_c;
    logic [WIDTH-1:0] f_r_q;
    logic [WIDTH-1:0] f_r_d;
    logic             out_valid_q;
    logic             out_valid_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nand2_cell u_cell (
            .a_i (bus.A[i]),
            .b_i (bus.B[i]),
            .y_o (f_c[i])
        );
    end

    assign bus.F         = f_c;
    assign bus.F_r       = f_r_q;
    assign bus.out_valid = out_valid_q;

    always_comb begin
        f_r_d       = f_r_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            f_r_d       = WIDTH'(nand2_f(NAND2_MAX_W'(bus.A), NAND2_MAX_W'(bus.B)));
            out_valid_d = 1'b1;
        end
    end

    // Reset value is the NAND of two zero operands, i.e. all lanes high.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_r_q       <= {WIDTH{1'b1}};
            out_valid_q <= 1'b0;
        end else begin
            f_r_q       <= f_r_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef NAND2_STATS_EN
    logic [CNT_W-1:0] zero_cnt_q;
    logic [CNT_W-1:0] zero_cnt_d;
    logic             any_zero_c;

    assign any_zero_c   = |(~f_c);
    assign bus.zero_cnt = zero_cnt_q;

    // Saturating count of captures where at least one lane had A=B=1.
    always_comb begin
        zero_cnt_d = zero_cnt_q;
        if (bus.in_valid && any_zero_c && (zero_cnt_q != {CNT_W{1'b1}})) begin
            zero_cnt_d = zero_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_cnt_q <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_nand2_gate.sv
// Self-checking bench for nand2_gate: a WIDTH=1/CNT_W=2 instance and a WIDTH=4/CNT_W=16 instance.
// Reference model works lane by lane from the truth table, independent of the RTL.
module tb_nand2_gate;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nand2_if #(.WIDTH(1), .CNT_W(2))  if1 ();
    nand2_if #(.WIDTH(4), .CNT_W(16)) if4 ();

    nand2_gate #(.WIDTH(1), .CNT_W(2))  u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    nand2_gate #(.WIDTH(4), .CNT_W(16)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    // Reference model state
    logic [0:0] m1_fr;
    logic [3:0] m4_fr;
    logic       m1_ov;
    logic       m4_ov;
    int         m1_cnt;
    int         m4_cnt;

    function automatic logic [3:0] ref_nand(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ((int'(a[i]) + int'(b[i])) == 2) ? 1'b0 : 1'b1;
        return r;
    endfunction

    function automatic bit ref_any_both_high(input logic [3:0] a, input logic [3:0] b, input int w);
        int n;
        n = 0;
        for (int i = 0; i < w; i++) if (a[i] && b[i]) n++;
        return n > 0;
    endfunction

    // Advance the model using the inputs currently applied, then step one edge.
    task automatic clock_edge();
        if (rst) begin
            m1_fr = 1'b1; m4_fr = 4'hF; m1_ov = 1'b0; m4_ov = 1'b0; m1_cnt = 0; m4_cnt = 0;
        end else begin
            if (if1.in_valid) begin
                m1_fr = ref_nand({3'b0, if1.A}, {3'b0, if1.B}) & 4'h1;
                m1_ov = 1'b1;
                if (ref_any_both_high({3'b0, if1.A}, {3'b0, if1.B}, 1) && m1_cnt < 3) m1_cnt++;
            end else m1_ov = 1'b0;
            if (if4.in_valid) begin
                m4_fr = ref_nand(if4.A, if4.B);
                m4_ov = 1'b1;
                if (ref_any_both_high(if4.A, if4.B, 4) && m4_cnt < 65535) m4_cnt++;
            end else m4_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_truth_table();
        logic [1:0] pat;
        logic [0:0] exp [4];
        exp[0] = 1'b1; exp[1] = 1'b1; exp[2] = 1'b1; exp[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pat = 2'(i);
            if1.A = pat[1];
            if1.B = pat[0];
            #1;
            checks++;
            if (if1.F !== exp[i]) begin
                errors++;
                $display("FAIL truth_table A=%b B=%b: got F=%b expected %b", pat[1], pat[0], if1.F, exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if1.in_valid = 1'b1; if1.A = 1'b1; if1.B = 1'b1;
        if4.in_valid = 1'b1; if4.A = 4'hF; if4.B = 4'hF;
        #1;
        for (int e = 0; e < 2; e++) begin
            clock_edge();
            checks++;
            if (if1.F_r !== 1'b1 || if1.out_valid !== 1'b0 || if1.F !== 1'b0) begin
                errors++;
                $display("FAIL reset_w1 edge%0d: got F_r=%b ov=%b F=%b expected 1 0 0", e, if1.F_r, if1.out_valid, if1.F);
            end
            checks++;
            if (if4.F_r !== 4'hF || if4.out_valid !== 1'b0 || if4.F !== 4'h0) begin
                errors++;
                $display("FAIL reset_w4 edge%0d: got F_r=%h ov=%b F=%h expected F 0 0", e, if4.F_r, if4.out_valid, if4.F);
            end
        end
        rst = 1'b0;
        if1.in_valid = 1'b0;
        if4.in_valid = 1'b0;
    endtask

    task automatic test_pipeline();
        logic [3:0] a_v [3];
        logic [3:0] b_v [3];
        logic [3:0] exp [3];
        a_v[0] = 4'hF; b_v[0] = 4'hF; exp[0] = 4'h0;
        a_v[1] = 4'hA; b_v[1] = 4'h5; exp[1] = 4'hF;
        a_v[2] = 4'h0; b_v[2] = 4'hF; exp[2] = 4'hF;
        // 0xA & 0x5 = 0, so the middle result is all ones; the spec's D uses A&5 = 0 -> F? use model
        exp[1] = ref_nand(a_v[1], b_v[1]);
        for (int i = 0; i < 3; i++) begin
            if4.in_valid = 1'b1; if4.A = a_v[i]; if4.B = b_v[i];
            clock_edge();
            checks++;
            if (if4.F_r !== exp[i] || if4.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL pipeline_%0d: got F_r=%h ov=%b expected %h 1", i, if4.F_r, if4.out_valid, exp[i]);
            end
        end
        if4.in_valid = 1'b0;
        clock_edge();
        checks++;
        if (if4.out_valid !== 1'b0 || if4.F_r !== exp[2]) begin
            errors++;
            $display("FAIL pipeline_end: got F_r=%h ov=%b expected %h 0", if4.F_r, if4.out_valid, exp[2]);
        end
    endtask

    task automatic test_hold();
        logic [3:0] held;
        if4.in_valid = 1'b1; if4.A = 4'h3; if4.B = 4'h6;
        clock_edge();
        held = 4'hD;
        if4.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if4.A = 4'($urandom); if4.B = 4'($urandom);
            #1;
            checks++;
            if (if4.F !== ref_nand(if4.A, if4.B)) begin
                errors++;
                $display("FAIL hold_F: got %h expected %h", if4.F, ref_nand(if4.A, if4.B));
            end
            clock_edge();
            checks++;
            if (if4.F_r !== held || if4.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_reg: got F_r=%h ov=%b expected %h 0", if4.F_r, if4.out_valid, held);
            end
        end
    endtask

    task automatic test_mid_reset();
        if4.in_valid = 1'b1; if4.A = 4'hF; if4.B = 4'hF;
        clock_edge();
        checks++;
        if (if4.F_r !== 4'h0 || if4.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre: got F_r=%h ov=%b expected 0 1", if4.F_r, if4.out_valid);
        end
        rst = 1'b1;
        clock_edge();
        checks++;
        if (if4.F_r !== 4'hF || if4.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got F_r=%h ov=%b expected F 0", if4.F_r, if4.out_valid);
        end
        rst = 1'b0;
        if4.in_valid = 1'b0;
    endtask

`ifdef NAND2_STATS_EN
    task automatic test_stats_saturate();
        int exp [5];
        exp[0] = 1; exp[1] = 2; exp[2] = 3; exp[3] = 3; exp[4] = 3;
        rst = 1'b1;
        clock_edge();
        rst = 1'b0;
        if1.in_valid = 1'b1; if1.A = 1'b1; if1.B = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clock_edge();
            checks++;
            if (if1.zero_cnt !== 2'(exp[i])) begin
                errors++;
                $display("FAIL stats_cnt_%0d: got %0d expected %0d", i, if1.zero_cnt, exp[i]);
            end
        end
        rst = 1'b1;
        clock_edge();
        checks++;
        if (if1.zero_cnt !== 2'd0) begin
            errors++;
            $display("FAIL stats_reset: got %0d expected 0", if1.zero_cnt);
        end
        rst = 1'b0;
        if1.in_valid = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 19) == 0);
            if1.in_valid = 1'($urandom); if1.A = 1'($urandom); if1.B = 1'($urandom);
            if4.in_valid = 1'($urandom); if4.A = 4'($urandom); if4.B = 4'($urandom);
            #1;
            checks++;
            if (if4.F !== ref_nand(if4.A, if4.B) || if1.F !== ref_nand({3'b0, if1.A}, {3'b0, if1.B}) % 2) begin
                errors++;
                $display("FAIL rand_F n=%0d: got %h/%b", n, if4.F, if1.F);
            end
            clock_edge();
            checks++;
            if (if4.F_r !== m4_fr || if4.out_valid !== m4_ov || if1.F_r !== m1_fr || if1.out_valid !== m1_ov) begin
                errors++;
                $display("FAIL rand_reg n=%0d: got %h/%b %b/%b expected %h/%b %b/%b",
                         n, if4.F_r, if4.out_valid, if1.F_r, if1.out_valid, m4_fr, m4_ov, m1_fr, m1_ov);
            end
`ifdef NAND2_STATS_EN
            checks++;
            if (if4.zero_cnt !== 16'(m4_cnt) || if1.zero_cnt !== 2'(m1_cnt)) begin
                errors++;
                $display("FAIL rand_cnt n=%0d: got %0d/%0d expected %0d/%0d",
                         n, if4.zero_cnt, if1.zero_cnt, m4_cnt, m1_cnt);
            end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        if1.in_valid = 1'b0; if1.A = 1'b0; if1.B = 1'b0;
        if4.in_valid = 1'b0; if4.A = 4'h0; if4.B = 4'h0;
        m1_fr = 1'b1; m4_fr = 4'hF; m1_ov = 1'b0; m4_ov = 1'b0; m1_cnt = 0; m4_cnt = 0;
        test_truth_table();
        test_reset();
        test_pipeline();
        test_hold();
        test_mid_reset();
`ifdef NAND2_STATS_EN
        test_stats_saturate();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
